// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Bundle between the hardwired control unit and the datapath it steers.
//   run, stop, mem_rdy, ir      : datapath/operator -> sequencer
//   PC/MAR/MDR/IR/Y/Z/HI/LO strobes, Rin, Rout, alu_op, halted, illegal
//                               : sequencer -> datapath
// Modports:
//   master : the sequencer (drives strobes, consumes IR and handshakes)
//   slave  : the datapath / environment side
// ---------------------------------------------------------------------------
interface alu_sequencer_if;
  logic        run;
  logic        stop;
  logic        mem_rdy;
  logic [31:0] ir;

  logic        PCout;
  logic        MARin;
  logic        IncPC;
  logic        PCin;
  logic        MDMuxread;
  logic        MDRin;
  logic        MDRout;
  logic        IRin;
  logic        Yin;
  logic        Zlowin;
  logic        Zhighin;
  logic        Zlowout;
  logic        Zhighout;
  logic        LOin;
  logic        HIin;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic [12:0] alu_op;
  logic        halted;
  logic        illegal;

  modport master (
    input  run, stop, mem_rdy, ir,
    output PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin, Yin,
           Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
           Rin, Rout, alu_op, halted, illegal
  );

  modport slave (
    output run, stop, mem_rdy, ir,
    input  PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin, Yin,
           Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin,
           Rin, Rout, alu_op, halted, illegal
  );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Hardwired control unit: fetches an instruction over a ready handshake,
// decodes opcode/ra/rb/rc from IR and steps the datapath strobes through
// T0..T6 for register-format ALU instructions, then loops or halts.
// Ports:
//   clock : rising-edge system clock
//   clear : asynchronous active-low reset (forces HALT, all strobes low)
//   bus   : alu_sequencer_if.master (handshakes, IR, all datapath strobes)
// Strobes are a pure decode of the state registers; the only input that
// reaches them is IR in T3, which is the datapath's own register.
// ---------------------------------------------------------------------------
module alu_sequencer #(
  parameter int OPW = 5,
  parameter int RSW = 4
) (
  input  logic            clock,
  input  logic            clear,
  alu_sequencer_if.master bus
);

  localparam int NREG = 1 << RSW;

  localparam logic [2:0] S_HALT = 3'd0;
  localparam logic [2:0] S_T0   = 3'd1;
  localparam logic [2:0] S_T1   = 3'd2;
  localparam logic [2:0] S_T2   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
  localparam logic [2:0] S_T5   = 3'd6;
  localparam logic [2:0] S_T6   = 3'd7;

  localparam logic [1:0] CLS_BIN  = 2'd0;
  localparam logic [1:0] CLS_WIDE = 2'd1;
  localparam logic [1:0] CLS_UN   = 2'd2;
  localparam logic [1:0] CLS_ILL  = 2'd3;

  // Opcode -> {class, alu_op bit index}
  function automatic logic [5:0] decode_op(input logic [OPW-1:0] op);
    logic [5:0] r;
    case (op)
      OPW'(5'b00011): r = {CLS_BIN,  4'd0};
      OPW'(5'b00100): r = {CLS_BIN,  4'd1};
      OPW'(5'b00101): r = {CLS_BIN,  4'd2};
      OPW'(5'b00110): r = {CLS_BIN,  4'd3};
      OPW'(5'b00111): r = {CLS_BIN,  4'd4};
      OPW'(5'b01000): r = {CLS_BIN,  4'd5};
      OPW'(5'b01001): r = {CLS_BIN,  4'd6};
      OPW'(5'b01010): r = {CLS_BIN,  4'd7};
      OPW'(5'b01011): r = {CLS_BIN,  4'd8};
      OPW'(5'b01111): r = {CLS_WIDE, 4'd9};
      OPW'(5'b10000): r = {CLS_WIDE, 4'd10};
      OPW'(5'b10001): r = {CLS_UN,   4'd11};
      OPW'(5'b10010): r = {CLS_UN,   4'd12};
      default:        r = {CLS_ILL,  4'd0};
    endcase
    return r;
  endfunction

  function automatic logic [NREG-1:0] reg_onehot(input logic [RSW-1:0] r);
    return {{(NREG-1){1'b0}}, 1'b1} << r;
  endfunction

  function automatic logic [12:0] alu_onehot(input logic [3:0] idx);
    return 13'd1 << idx;
  endfunction

  // IR fields
  logic [OPW-1:0] op_s;
  logic [RSW-1:0] ra_s, rb_s, rc_s;
  logic [1:0]     dec_cls_s;
  logic [3:0]     dec_idx_s;
  logic           ir_unused_s;

  assign op_s        = bus.ir[31 -: OPW];
  assign ra_s        = bus.ir[31-OPW -: RSW];
  assign rb_s        = bus.ir[31-OPW-RSW -: RSW];
  assign rc_s        = bus.ir[31-OPW-2*RSW -: RSW];
  assign ir_unused_s = ^bus.ir[31-OPW-3*RSW:0];
  assign {dec_cls_s, dec_idx_s} = decode_op(op_s);

  logic [2:0]     state_q, state_d;
  logic           first_t1_q, first_t1_d;
  logic           stop_pending_q, stop_pending_d;
  logic           illegal_q, illegal_d;
  logic [1:0]     cls_q, cls_d;
  logic [3:0]     idx_q, idx_d;
  logic [RSW-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;

  logic           instr_end_s;
  logic [2:0]     end_next_s;

  // Last execute step of each class, and where it leads
  always_comb begin
    instr_end_s = 1'b0;
    if (state_q == S_T4 && cls_q == CLS_UN) begin
      instr_end_s = 1'b1;
    end else if (state_q == S_T5 && cls_q == CLS_BIN) begin
      instr_end_s = 1'b1;
    end else if (state_q == S_T6) begin
      instr_end_s = 1'b1;
    end else begin
      instr_end_s = 1'b0;
    end
    // A stop arriving on the final step still halts.
    if (stop_pending_q || bus.stop || !bus.run) begin
      end_next_s = S_HALT;
    end else begin
      end_next_s = S_T0;
    end
  end

  // Next-state, decode capture and sticky flag logic
  always_comb begin
    state_d        = state_q;
    first_t1_d     = 1'b0;
    stop_pending_d = stop_pending_q;
    illegal_d      = illegal_q;
    cls_d          = cls_q;
    idx_d          = idx_q;
    ra_d           = ra_q;
    rb_d           = rb_q;
    rc_d           = rc_q;
    case (state_q)
      S_HALT: begin
        if (bus.run) begin
          state_d = S_T0;
        end else begin
          state_d = S_HALT;
        end
      end
      S_T0: begin
        state_d    = S_T1;
        first_t1_d = 1'b1;
      end
      S_T1: begin
        if (bus.mem_rdy) begin
          state_d = S_T2;
        end else begin
          state_d = S_T1;
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        // IR is stable from here; keep a private copy for T4..T6.
        cls_d = dec_cls_s;
        idx_d = dec_idx_s;
        ra_d  = ra_s;
        rb_d  = rb_s;
        rc_d  = rc_s;
        if (dec_cls_s == CLS_ILL) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_T4;
        end
      end
      S_T4: begin
        if (cls_q == CLS_UN) begin
          state_d = end_next_s;
        end else begin
          state_d = S_T5;
        end
      end
      S_T5: begin
        if (cls_q == CLS_BIN) begin
          state_d = end_next_s;
        end else begin
          state_d = S_T6;
        end
      end
      S_T6:    state_d = end_next_s;
      default: state_d = S_HALT;
    endcase

    if (state_q == S_HALT && bus.run) begin
      stop_pending_d = 1'b0;
    end else if (instr_end_s) begin
      stop_pending_d = 1'b0;
    end else if (bus.stop) begin
      stop_pending_d = 1'b1;
    end else begin
      stop_pending_d = stop_pending_q;
    end
  end

  // State and captured-decode registers
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q        <= S_HALT;
      first_t1_q     <= 1'b0;
      stop_pending_q <= 1'b0;
      illegal_q      <= 1'b0;
      cls_q          <= CLS_BIN;
      idx_q          <= 4'd0;
      ra_q           <= '0;
      rb_q           <= '0;
      rc_q           <= '0;
    end else begin
      state_q        <= state_d;
      first_t1_q     <= first_t1_d;
      stop_pending_q <= stop_pending_d;
      illegal_q      <= illegal_d;
      cls_q          <= cls_d;
      idx_q          <= idx_d;
      ra_q           <= ra_d;
      rb_q           <= rb_d;
      rc_q           <= rc_d;
    end
  end

  // Strobe decode from the current step
  always_comb begin
    bus.PCout     = 1'b0;
    bus.MARin     = 1'b0;
    bus.IncPC     = 1'b0;
    bus.PCin      = 1'b0;
    bus.MDMuxread = 1'b0;
    bus.MDRin     = 1'b0;
    bus.MDRout    = 1'b0;
    bus.IRin      = 1'b0;
    bus.Yin       = 1'b0;
    bus.Zlowin    = 1'b0;
    bus.Zhighin   = 1'b0;
    bus.Zlowout   = 1'b0;
    bus.Zhighout  = 1'b0;
    bus.LOin      = 1'b0;
    bus.HIin      = 1'b0;
    bus.Rin       = '0;
    bus.Rout      = '0;
    bus.alu_op    = 13'd0;
    bus.halted    = (state_q == S_HALT);
    bus.illegal   = illegal_q;
    case (state_q)
      S_T0: begin
        bus.PCout  = 1'b1;
        bus.MARin  = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Zlowin = 1'b1;
      end
      S_T1: begin
        // MDR keeps loading through the wait; PC is written once only.
        bus.MDMuxread = 1'b1;
        bus.MDRin     = 1'b1;
        bus.PCin      = first_t1_q;
        bus.Zlowout   = first_t1_q;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        case (dec_cls_s)
          CLS_BIN: begin
            bus.Rout = reg_onehot(rb_s);
            bus.Yin  = 1'b1;
          end
          CLS_WIDE: begin
            bus.Rout = reg_onehot(ra_s);
            bus.Yin  = 1'b1;
          end
          CLS_UN: begin
            bus.Rout   = reg_onehot(rb_s);
            bus.alu_op = alu_onehot(dec_idx_s);
            bus.Zlowin = 1'b1;
          end
          default: bus.Yin = 1'b0;
        endcase
      end
      S_T4: begin
        case (cls_q)
          CLS_BIN: begin
            bus.Rout   = reg_onehot(rc_q);
            bus.alu_op = alu_onehot(idx_q);
            bus.Zlowin = 1'b1;
          end
          CLS_WIDE: begin
            bus.Rout    = reg_onehot(rb_q);
            bus.alu_op  = alu_onehot(idx_q);
            bus.Zlowin  = 1'b1;
            bus.Zhighin = 1'b1;
          end
          CLS_UN: begin
            bus.Zlowout = 1'b1;
            bus.Rin     = reg_onehot(ra_q);
          end
          default: bus.Zlowin = 1'b0;
        endcase
      end
      S_T5: begin
        case (cls_q)
          CLS_BIN: begin
            bus.Zlowout = 1'b1;
            bus.Rin     = reg_onehot(ra_q);
          end
          CLS_WIDE: begin
            bus.Zlowout = 1'b1;
            bus.LOin    = 1'b1;
          end
          default: bus.Zlowout = 1'b0;
        endcase
      end
      S_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      default: bus.halted = (state_q == S_HALT);
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Directed and randomized instruction streams. For each instruction the
// bench lists the strobes every step must show (from the instruction-class
// rules) and compares the DUT cycle by cycle.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

  logic clock;
  logic clear;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        pc_out, mar_in, inc_pc, pc_in, md_mux_read, mdr_in, mdr_out,
                 ir_in, y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, lo_in, hi_in;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [12:0] alu_op;
    logic        halted;
    logic        illegal;
  } obs_t;

  // Supported opcodes in alu_op bit order
  logic [4:0] op_list [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                               5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};

  int checks = 0;
  int errors = 0;
  bit ill_m = 1'b0;
  bit pend_m = 1'b0;
  bit halted_m = 1'b1;

  function automatic obs_t observe();
    obs_t o;
    o.pc_out = bus.PCout;        o.mar_in = bus.MARin;
    o.inc_pc = bus.IncPC;        o.pc_in = bus.PCin;
    o.md_mux_read = bus.MDMuxread; o.mdr_in = bus.MDRin;
    o.mdr_out = bus.MDRout;      o.ir_in = bus.IRin;
    o.y_in = bus.Yin;            o.zlow_in = bus.Zlowin;
    o.zhigh_in = bus.Zhighin;    o.zlow_out = bus.Zlowout;
    o.zhigh_out = bus.Zhighout;  o.lo_in = bus.LOin;
    o.hi_in = bus.HIin;          o.rin = bus.Rin;
    o.rout = bus.Rout;           o.alu_op = bus.alu_op;
    o.halted = bus.halted;       o.illegal = bus.illegal;
    return o;
  endfunction

  function automatic obs_t blank(input bit h);
    obs_t e;
    e = '0;
    e.halted = h;
    e.illegal = ill_m;
    return e;
  endfunction

  function automatic logic [15:0] r1h(input int r);
    logic [15:0] v;
    v = 16'd1;
    return v << r;
  endfunction

  task automatic check(input string tag, input obs_t exp);
    obs_t got;
    got = observe();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_from_halt(input string tag);
    bus.stop = 1'b0;
    bus.run  = 1'b1;
    check({tag, " halt"}, blank(1'b1));
    @(posedge clock); #1;
    pend_m   = 1'b0;
    halted_m = 1'b0;
  endtask

  // Run one instruction starting in T0; returns with DUT in T0 or HALT.
  task automatic do_instr(input logic [31:0] ir_v, input int waits, input int stop_at,
                          input bit keep, input int abort_at, input string tag);
    obs_t exp_q[$];
    obs_t e;
    int cls, idx, ra, rb, rc, len;
    bit saw_stop;
    idx = -1;
    for (int i = 0; i < 13; i++) if (op_list[i] == ir_v[31:27]) idx = i;
    if (idx < 0) cls = 0;
    else if (idx < 9) cls = 1;
    else if (idx < 11) cls = 2;
    else cls = 3;
    ra = int'(ir_v[26:23]); rb = int'(ir_v[22:19]); rc = int'(ir_v[18:15]);

    e = blank(1'b0); e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.zlow_in = 1; exp_q.push_back(e);
    for (int w = 0; w <= waits; w++) begin
      e = blank(1'b0); e.md_mux_read = 1; e.mdr_in = 1;
      if (w == 0) begin e.pc_in = 1; e.zlow_out = 1; end
      exp_q.push_back(e);
    end
    e = blank(1'b0); e.mdr_out = 1; e.ir_in = 1; exp_q.push_back(e);
    case (cls)
      1: begin
        e = blank(1'b0); e.rout = r1h(rb); e.y_in = 1; exp_q.push_back(e);
        e = blank(1'b0); e.rout = r1h(rc); e.alu_op = 13'd1 << idx; e.zlow_in = 1; exp_q.push_back(e);
        e = blank(1'b0); e.zlow_out = 1; e.rin = r1h(ra); exp_q.push_back(e);
      end
      2: begin
        e = blank(1'b0); e.rout = r1h(ra); e.y_in = 1; exp_q.push_back(e);
        e = blank(1'b0); e.rout = r1h(rb); e.alu_op = 13'd1 << idx;
        e.zlow_in = 1; e.zhigh_in = 1; exp_q.push_back(e);
        e = blank(1'b0); e.zlow_out = 1; e.lo_in = 1; exp_q.push_back(e);
        e = blank(1'b0); e.zhigh_out = 1; e.hi_in = 1; exp_q.push_back(e);
      end
      3: begin
        e = blank(1'b0); e.rout = r1h(rb); e.alu_op = 13'd1 << idx; e.zlow_in = 1; exp_q.push_back(e);
        e = blank(1'b0); e.zlow_out = 1; e.rin = r1h(ra); exp_q.push_back(e);
      end
      default: begin
        e = blank(1'b0); exp_q.push_back(e);
      end
    endcase

    len = exp_q.size();
    bus.ir = ir_v;
    saw_stop = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (k >= 1 && k <= waits + 1) bus.mem_rdy = (k == waits + 1);
      else bus.mem_rdy = 1'($urandom_range(0, 1));
      bus.stop = (k == stop_at);
      if (k == stop_at) saw_stop = 1'b1;
      bus.run = (k == len - 1) ? keep : 1'b1;
      check($sformatf("%s c%0d", tag, k), exp_q[k]);
      if (k == abort_at) begin
        clear = 1'b0;
        #1;
        ill_m = 1'b0; pend_m = 1'b0; halted_m = 1'b1;
        check({tag, " async clear"}, blank(1'b1));
        bus.stop = 1'b0; bus.run = 1'b0;
        @(posedge clock); #1;
        clear = 1'b1;
        check({tag, " after clear"}, blank(1'b1));
        return;
      end
      @(posedge clock); #1;
    end
    bus.stop = 1'b0;
    if (cls == 0) begin
      ill_m = 1'b1;
      halted_m = 1'b1;
      pend_m = pend_m | saw_stop;
    end else begin
      halted_m = pend_m | saw_stop | !keep;
      pend_m = 1'b0;
    end
    if (halted_m) begin
      bus.run = 1'b0;
      check({tag, " end halt"}, blank(1'b1));
    end
  endtask

  initial begin
    logic [31:0] ir_r;
    int n_waits, st, pick;
    bit keep_r;
    clear = 1'b0;
    bus.run = 1'b0; bus.stop = 1'b0; bus.mem_rdy = 1'b0; bus.ir = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check("reset", blank(1'b1));
    clear = 1'b1;
    @(posedge clock); #1;
    check("idle after reset", blank(1'b1));

    // Directed MUL, ADD, NEG back to back
    start_from_halt("mul");
    do_instr(32'h7A280000, 0, -1, 1'b1, -1, "mul");
    do_instr(32'h18918000, 0, -1, 1'b1, -1, "add");
    do_instr(32'h8B380000, 0, -1, 1'b1, -1, "neg");
    // Memory wait of 3 cycles plus a stop pulse during T1
    do_instr(32'h18918000, 3, 2, 1'b1, -1, "add wait stop");

    // Illegal opcode: sticky flag, waits in HALT until run
    start_from_halt("ill");
    do_instr(32'hF8000000, 0, -1, 1'b1, -1, "ill");
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("ill hold", blank(1'b1));
    end
    // Stop while halted only sets the pending flag, which run clears
    bus.stop = 1'b1;
    @(posedge clock); #1;
    bus.stop = 1'b0;
    pend_m = 1'b1;
    check("stop in halt", blank(1'b1));
    start_from_halt("after ill");
    do_instr(32'h18918000, 0, -1, 1'b1, -1, "add after ill");

    // Randomized stream
    for (int n = 0; n < 30; n++) begin
      if (halted_m) start_from_halt("rnd");
      pick = int'($urandom_range(0, 15));
      if (pick == 0) begin
        ir_r = 32'($urandom);
        ir_r[31:27] = 5'd31 - 5'($urandom_range(0, 9));  // 22..31: all unsupported
      end else begin
        ir_r = 32'($urandom);
        ir_r[31:27] = op_list[$urandom_range(0, 12)];
      end
      n_waits = int'($urandom_range(0, 3));
      st = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 8)) : -1;
      keep_r = ($urandom_range(0, 5) != 0);
      do_instr(ir_r, n_waits, st, keep_r, -1, $sformatf("rnd%0d", n));
    end

    // Asynchronous clear during T4 of a MUL
    if (halted_m) start_from_halt("abort");
    do_instr(32'h7A280000, 0, -1, 1'b1, 4, "mul abort");

    // Final NOT, then halt on run low
    start_from_halt("last");
    do_instr(32'h92100000, 1, -1, 1'b0, -1, "not last");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
